// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the issuing pipeline stage and the HI/LO multiply/divide unit.
// Start is accepted on the rising edge where Busy=0. Done pulses for one cycle when Hi/Lo hold a new result.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             Start;
   logic [1:0]       Op;
   logic [WIDTH-1:0] OperandA;
   logic [WIDTH-1:0] OperandB;
   logic             HiWrite;
   logic             LoWrite;
   logic [WIDTH-1:0] WriteData;
   logic             Busy;
   logic             Done;
   logic             DivByZero;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   logic [1:0]       dbg_state;

   modport master (
      output Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
      input  Busy, Done, DivByZero, Hi, Lo, dbg_state
   );

   modport slave (
      input  Start, Op, OperandA, OperandB, HiWrite, LoWrite, WriteData,
      output Busy, Done, DivByZero, Hi, Lo, dbg_state
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// One shift-add / restoring shift-subtract step per cycle; fixed 33-edge latency.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            Clk,
   input logic            Reset,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state;
   logic               op_div;
   logic               sign_a;
   logic               sign_b;
   logic               b_zero;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   work;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      count;
   logic               busy;
   logic               done;
   logic               div_by_zero;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   logic               in_signed;
   logic               in_sign_a;
   logic               in_sign_b;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     partial;
   logic [WIDTH:0]     diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   orig_a;

   always_comb begin
      in_signed = ~bus.Op[0];
      in_sign_a = in_signed & bus.OperandA[WIDTH-1];
      in_sign_b = in_signed & bus.OperandB[WIDTH-1];
      add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? op_a : '0)};
      // Remainder lives in acc's upper half; the dividend shifts out of work's MSB.
      partial   = {acc[2*WIDTH-1:WIDTH], work[WIDTH-1]};
      diff      = partial - {1'b0, op_b};
      prod      = (sign_a ^ sign_b) ? -acc : acc;
      quo       = (sign_a ^ sign_b) ? -work : work;
      rem       = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      orig_a    = sign_a ? -op_a : op_a;
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         op_div      <= 1'b0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         b_zero      <= 1'b0;
         op_a        <= '0;
         op_b        <= '0;
         work        <= '0;
         acc         <= '0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         case (state)
            IDLE: begin
               done        <= 1'b0;
               div_by_zero <= 1'b0;
               if (bus.Start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  op_div <= bus.Op[1];
                  sign_a <= in_sign_a;
                  sign_b <= in_sign_b;
                  b_zero <= (bus.OperandB == '0);
                  op_a   <= in_sign_a ? -bus.OperandA : bus.OperandA;
                  op_b   <= in_sign_b ? -bus.OperandB : bus.OperandB;
                  // Multiplier bits are consumed LSB-first, dividend bits MSB-first.
                  if (bus.Op[1]) work <= in_sign_a ? -bus.OperandA : bus.OperandA;
                  else           work <= in_sign_b ? -bus.OperandB : bus.OperandB;
                  acc    <= '0;
                  count  <= '0;
               end else begin
                  if (bus.HiWrite) hi <= bus.WriteData;
                  if (bus.LoWrite) lo <= bus.WriteData;
               end
            end
            RUN: begin
               if (op_div) begin
                  acc[2*WIDTH-1:WIDTH] <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                  work                 <= {work[WIDTH-2:0], ~diff[WIDTH]};
               end else begin
                  acc  <= {add_sum, acc[WIDTH-1:1]};
                  work <= work >> 1;
               end
               count <= count + 1'b1;
               if (count == LAST) state <= FINISH;
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (!op_div) begin
                  hi <= prod[2*WIDTH-1:WIDTH];
                  lo <= prod[WIDTH-1:0];
               end else if (b_zero) begin
                  hi          <= orig_a;
                  lo          <= '1;
                  div_by_zero <= 1'b1;
               end else begin
                  hi <= rem;
                  lo <= quo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Busy      = busy;
   assign bus.Done      = done;
   assign bus.DivByZero = div_by_zero;
   assign bus.Hi        = hi;
   assign bus.Lo        = lo;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized and directed bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
   logic Clk;
   logic Reset;

   mult_div_unit_if bus ();

   mult_div_unit dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;
   logic [64:0] exp_q[$];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: {div_by_zero, hi, lo} straight from MIPS semantics using 64-bit arithmetic.
   function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      logic [31:0] q;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: begin
            p = sa * sb;
            return {1'b0, p};
         end
         2'd1: begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
         end
         2'd2: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            return {1'b0, r, q};
         end
         default: begin
            if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
            q = a / b;
            r = a % b;
            return {1'b0, r, q};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge where Done is observed.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
      logic [31:0] hold_hi;
      logic [31:0] hold_lo;
      logic [64:0] exp;
      int          waited;
      int          busy_cnt;
      bit          stable;
      bus.Start    = 1'b1;
      bus.Op       = op;
      bus.OperandA = a;
      bus.OperandB = b;
      exp_q.push_back(model(op, a, b));
      hold_hi = model_hi;
      hold_lo = model_lo;
      @(negedge Clk);
      bus.Start    = 1'b0;
      bus.HiWrite  = 1'b0;
      bus.LoWrite  = 1'b0;
      bus.OperandA = $urandom;
      bus.OperandB = $urandom;
      bus.Op       = 2'($urandom_range(0, 3));
      check_eq("busy_after_start", bus.Busy, 1);
      check_eq("done_drop", bus.Done, 0);
      waited   = 0;
      busy_cnt = 0;
      stable   = 1'b1;
      while (!bus.Done && waited < 60) begin
         if (bus.Busy) busy_cnt++;
         if (bus.Hi !== hold_hi || bus.Lo !== hold_lo) stable = 1'b0;
         if (inject && waited == 9) begin
            bus.Start     = 1'b1;
            bus.LoWrite   = 1'b1;
            bus.WriteData = 32'h0000_DEAD;
         end else begin
            bus.Start   = 1'b0;
            bus.LoWrite = 1'b0;
         end
         @(negedge Clk);
         waited++;
      end
      bus.Start   = 1'b0;
      bus.LoWrite = 1'b0;
      check_eq("latency", waited, 33);
      check_eq("busy_cycles", busy_cnt, 33);
      check_eq("hilo_stable", stable, 1);
      check_eq("busy_at_done", bus.Busy, 0);
      exp = exp_q.pop_front();
      check_eq("hi", bus.Hi, exp[63:32]);
      check_eq("lo", bus.Lo, exp[31:0]);
      check_eq("div_by_zero", bus.DivByZero, exp[64]);
      model_hi = exp[63:32];
      model_lo = exp[31:0];
   endtask

   task automatic idle_cycle();
      @(negedge Clk);
      check_eq("done_one_cycle", bus.Done, 0);
      check_eq("dbz_cleared", bus.DivByZero, 0);
      check_eq("idle_busy", bus.Busy, 0);
   endtask

   task automatic mt_write(input bit hw, input bit lw, input logic [31:0] data);
      bus.HiWrite   = hw;
      bus.LoWrite   = lw;
      bus.WriteData = data;
      @(negedge Clk);
      bus.HiWrite = 1'b0;
      bus.LoWrite = 1'b0;
      if (hw) model_hi = data;
      if (lw) model_lo = data;
      check_eq("mt_hi", bus.Hi, model_hi);
      check_eq("mt_lo", bus.Lo, model_lo);
   endtask

   initial begin
      bit          done_seen;
      logic [31:0] ra;
      logic [31:0] rb;

      Reset         = 1'b1;
      bus.Start     = 1'b0;
      bus.Op        = 2'd0;
      bus.OperandA  = '0;
      bus.OperandB  = '0;
      bus.HiWrite   = 1'b0;
      bus.LoWrite   = 1'b0;
      bus.WriteData = '0;
      repeat (3) @(negedge Clk);
      check_eq("rst_busy", bus.Busy, 0);
      check_eq("rst_done", bus.Done, 0);
      check_eq("rst_dbz", bus.DivByZero, 0);
      check_eq("rst_hi", bus.Hi, 0);
      check_eq("rst_lo", bus.Lo, 0);
      Reset = 1'b0;
      @(negedge Clk);

      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check_eq("multu_max_hi", bus.Hi, 32'hFFFF_FFFE);
      check_eq("multu_max_lo", bus.Lo, 32'h0000_0001);
      idle_cycle();
      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 0);
      check_eq("mult_neg_lo", bus.Lo, 32'hFFFF_FFF1);
      idle_cycle();
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);
      check_eq("mult_min_hi", bus.Hi, 32'h4000_0000);
      idle_cycle();
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
      check_eq("div_neg_lo", bus.Lo, 32'hFFFF_FFFD);
      check_eq("div_neg_hi", bus.Hi, 32'hFFFF_FFFF);
      idle_cycle();
      run_op(2'd3, 32'd100, 32'd7, 0);
      check_eq("divu_lo", bus.Lo, 32'd14);
      idle_cycle();
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check_eq("div_ovf_lo", bus.Lo, 32'h8000_0000);
      check_eq("div_ovf_hi", bus.Hi, 32'h0);
      idle_cycle();
      run_op(2'd3, 32'h1234, 32'h0, 0);
      check_eq("dbz_hi", bus.Hi, 32'h1234);
      check_eq("dbz_flag", bus.DivByZero, 1);
      idle_cycle();

      // Start and LoWrite mid-operation are both ignored.
      run_op(2'd1, 32'd3, 32'd4, 1);
      check_eq("inject_lo", bus.Lo, 32'd12);
      // Back-to-back: new Start issued in the Done cycle.
      run_op(2'd0, 32'd6, 32'hFFFF_FFFE, 0);
      idle_cycle();
      mt_write(1, 0, 32'hCAFE_F00D);
      check_eq("mthi_val", bus.Hi, 32'hCAFE_F00D);
      mt_write(1, 1, 32'h1357_9BDF);
      // Start wins over a simultaneous HiWrite.
      bus.HiWrite   = 1'b1;
      bus.WriteData = 32'hBAD0_BAD0;
      run_op(2'd3, 32'd9, 32'd4, 0);
      idle_cycle();

      // Asynchronous reset just after edge 20 of a MULT.
      bus.Start    = 1'b1;
      bus.Op       = 2'd0;
      bus.OperandA = $urandom;
      bus.OperandB = $urandom;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (19) @(negedge Clk);
      @(posedge Clk);
      #1 Reset = 1'b1;
      #1;
      check_eq("arst_busy", bus.Busy, 0);
      check_eq("arst_hi", bus.Hi, 0);
      check_eq("arst_lo", bus.Lo, 0);
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         if (bus.Done) done_seen = 1'b1;
      end
      Reset = 1'b0;
      repeat (40) begin
         @(negedge Clk);
         if (bus.Done) done_seen = 1'b1;
      end
      check_eq("arst_no_done", done_seen, 0);
      model_hi = '0;
      model_lo = '0;
      run_op(2'd0, 32'hFFFF_FFF0, 32'd3, 0);
      idle_cycle();

      for (int i = 0; i < 50; i++) begin
         if ($urandom_range(0, 9) == 0) begin
            mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end else begin
            ra = pick();
            rb = pick();
            run_op(2'($urandom_range(0, 3)), ra, rb, 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
         end
      end
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit that consumes the two register-file read ports (ReadData1 → OperandA, ReadData2 → OperandB) and implements MIPS MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Executes one shift-add or shift-subtract step per cycle. Fixed latency regardless of operands.
- Also supports MTHI/MTLO writes.
- HI/LO outputs feed the MFHI/MFLO path back toward the register file's WriteData.

Parameters:
WIDTH, 32, operand/result width. Only 32 is supported; the iteration count equals WIDTH.

Ports:
Clk  input  1  clock, positive-edge triggered
Reset  input  1  asynchronous, active-high reset
Start  input  1  request an operation; sampled on rising edge of Clk
Op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
OperandA  input  32  multiplicand / dividend (rs)
OperandB  input  32  multiplier / divisor (rt)
HiWrite  input  1  MTHI: load WriteData into Hi
LoWrite  input  1  MTLO: load WriteData into Lo
WriteData  input  32  data for MTHI/MTLO
Busy  output  1  high while an operation is in progress
Done  output  1  one-cycle pulse when Hi/Lo hold a new result
DivByZero  output  1  valid with Done; high when a DIV/DIVU had OperandB=0
Hi  output  32  HI register (product[63:32] / remainder)
Lo  output  32  LO register (product[31:0] / quotient)

Behaviour:
- Reset (async, any time, including mid-operation):
  - State goes to IDLE; Hi=Lo=0; Busy=0; Done=0; DivByZero=0.
  - Any in-flight operation is discarded.
- States:
  - IDLE → RUN on Start.
  - RUN → RUN while count<WIDTH.
  - RUN → FINISH when count reaches WIDTH.
  - FINISH → IDLE unconditionally.
- Edge 0 (Start=1 sampled in IDLE):
  - Latch Op, sign flags, and absolute values of OperandA/OperandB. Take absolute values only for signed ops; |0x80000000| = 0x80000000 unsigned.
  - Latch OperandB==0 flag.
  - Clear 64-bit accumulator and count. Busy=1 after this edge.
- Edges 1..32 (RUN), one iteration per edge:
  - Multiply: radix-2 shift-add, unsigned, on the absolute values.
  - Divide: restoring shift-subtract, unsigned, on the absolute values.
- Edge 33 (FINISH):
  - Apply sign correction:
    - product negated (64-bit two's complement) if operand signs differ, for MULT;
    - quotient negated if signs differ, for DIV;
    - remainder takes the dividend's sign, for DIV.
  - Write Hi/Lo; Busy=0; Done=1 for exactly the cycle following edge 33.
  - Net latency: result visible 33 edges after the Start edge.
- Divide by zero:
  - Still takes the full 33 cycles.
  - Result: Hi=original OperandA, Lo=0xFFFFFFFF, DivByZero=1 with Done. DivByZero is cleared at the next edge.
- DIV overflow (0x80000000 / 0xFFFFFFFF): Lo=0x80000000, Hi=0. No flag.
- Start while Busy=1: ignored and not queued.
- Start in the Done cycle: accepted, because the state is IDLE. Done deasserts at that edge.
- MTHI/MTLO:
  - Honoured only while Busy=0; ignored while Busy=1.
  - Write takes effect at the edge.
  - If Start and HiWrite/LoWrite are asserted on the same edge, Start wins and the writes are dropped.
  - HiWrite and LoWrite together load both registers with WriteData.
- Hi/Lo are stable and unchanged from edge 0 until edge 33. Results are committed atomically only in FINISH.
- Op and Operand inputs are don't-care except at the Start edge.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 33 edges: Hi=0xFFFFFFFE, Lo=0x00000001, Done high one cycle, Busy high for exactly 33 cycles.
- MULT A=0xFFFFFFFD (−3), B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. MULT 0x80000000×0x80000000 → Hi=0x40000000, Lo=0.
- DIV A=0xFFFFFFF9 (−7), B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 → Lo=14, Hi=2. DIV 0x80000000/0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=0x1234, B=0 → Hi=0x1234, Lo=0xFFFFFFFF, DivByZero=1 with Done.
- Handshake:
  - Start MULTU 3×4, then Start plus LoWrite (data 0xDEAD) at edge 10 → both ignored; result Hi=0, Lo=12.
  - Start on the Done cycle → new op accepted; Busy=1 next cycle.
  - MTHI 0xCAFEF00D when idle → Hi=0xCAFEF00D next edge.
- Reset asserted asynchronously at edge 20 of a MULT → Hi=Lo=0, Busy=0, Done never pulses. A new Start after release completes normally.
